// File: rtl/peripheral_timer_bus_if.sv
// MEM-stage data-port bundle between the core and the peripheral block.
// Signal names follow the core's existing data-port naming.
interface peripheral_timer_bus_if;
    logic [31:0] iMemAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;

    modport master (
        output iMemAddr, iMemRead, iMemWrite, iMemWriteData,
        input  oMemReadData
    );

    modport slave (
        input  iMemAddr, iMemRead, iMemWrite, iMemWriteData,
        output oMemReadData
    );
endinterface

// File: rtl/peripheral_timer_bus.sv
// Memory-mapped peripherals on the core data port: reload timer with sticky IRQ,
// LED / 7-segment output registers, synchronised switch input and free-running systick.
module peripheral_timer_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    peripheral_timer_bus_if.slave       bus,
    output logic                        oInterrupt,
    input  logic [SW_W-1:0]             iSwitch,
    output logic [LED_W-1:0]            oLed,
    output logic [11:0]                 oDigi
);

    localparam logic [2:0] IDX_TH      = 3'd0;
    localparam logic [2:0] IDX_TL      = 3'd1;
    localparam logic [2:0] IDX_TCON    = 3'd2;
    localparam logic [2:0] IDX_LED     = 3'd3;
    localparam logic [2:0] IDX_SWITCH  = 3'd4;
    localparam logic [2:0] IDX_DIGI    = 3'd5;
    localparam logic [2:0] IDX_SYSTICK = 3'd6;

    logic [31:0]      th_q, th_d;
    logic [31:0]      tl_q, tl_d;
    logic [2:0]       tcon_q, tcon_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [11:0]      digi_q, digi_d;
    logic [31:0]      systick_q, systick_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

    logic       hit;
    logic [2:0] idx;
    logic       wr_en;
    logic       overflow;
    logic [31:0] rdata;

    assign hit      = (bus.iMemAddr[31:5] == BASE_ADDR[31:5]);
    assign idx      = bus.iMemAddr[4:2];
    assign wr_en    = bus.iMemWrite & hit;
    assign overflow = tcon_q[0] & (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        if (overflow && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end

        // CPU writes override the timer update; a TCON write cannot swallow an IRQ it enables
        if (wr_en) begin
            unique case (idx)
                IDX_TH:   th_d   = bus.iMemWriteData;
                IDX_TL:   tl_d   = bus.iMemWriteData;
                IDX_TCON: tcon_d = {bus.iMemWriteData[2] | (overflow & bus.iMemWriteData[1]),
                                    bus.iMemWriteData[1:0]};
                IDX_LED:  led_d  = bus.iMemWriteData[LED_W-1:0];
                IDX_DIGI: digi_d = bus.iMemWriteData[11:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
            sw_meta_q <= iSwitch;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.iMemRead && hit) begin
            unique case (idx)
                IDX_TH:      rdata = th_q;
                IDX_TL:      rdata = tl_q;
                IDX_TCON:    rdata[2:0] = tcon_q;
                IDX_LED:     rdata[LED_W-1:0] = led_q;
                IDX_SWITCH:  rdata[SW_W-1:0] = sw_sync_q;
                IDX_DIGI:    rdata[11:0] = digi_q;
                IDX_SYSTICK: rdata = systick_q;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.oMemReadData = rdata;
    assign oInterrupt       = tcon_q[2];
    assign oLed             = led_q;
    assign oDigi            = digi_q;

endmodule

// File: tb/tb_peripheral_timer_bus.sv
// Directed bench for peripheral_timer_bus: register map, timer reload/IRQ races,
// switch synchroniser latency, address decode and asynchronous reset.
module tb_peripheral_timer_bus;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic       clk;
    logic       reset;
    logic       oInterrupt;
    logic [7:0] iSwitch;
    logic [7:0] oLed;
    logic [11:0] oDigi;

    int n_cmp;
    int n_err;

    peripheral_timer_bus_if bus ();

    peripheral_timer_bus #(
        .BASE_ADDR (BASE),
        .LED_W     (8),
        .SW_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .oInterrupt (oInterrupt),
        .iSwitch    (iSwitch),
        .oLed       (oLed),
        .oDigi      (oDigi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.iMemAddr      = a;
        bus.iMemWriteData = d;
        bus.iMemWrite     = 1'b1;
        @(posedge clk);
        #1;
        bus.iMemWrite     = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.iMemAddr = a;
        bus.iMemRead = 1'b1;
        #1;
        d = bus.oMemReadData;
        bus.iMemRead = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(BASE + 32'(idx * 4), d);
        chk_eq(tag, d, exp);
    endtask

    logic [31:0] rd_v;
    logic [31:0] tick_a;

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.iMemAddr      = '0;
        bus.iMemRead      = 1'b0;
        bus.iMemWrite     = 1'b0;
        bus.iMemWriteData = '0;
        iSwitch = 8'h3C;
        reset   = 1'b1;
        #23;
        chk_eq("rst_irq", {31'd0, oInterrupt}, 32'd0);
        chk_reg("rst_sw_held", 4, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk_reg("rst_th", 0, 32'h0);
        chk_reg("rst_tl", 1, 32'h0);
        chk_reg("rst_tcon", 2, 32'h0);
        chk_reg("rst_led", 3, 32'h0);
        chk_reg("rst_sw", 4, 32'h0000_003C);
        chk_reg("rst_digi", 5, 32'h0);
        bus_rd(BASE + 32'h18, rd_v);
        chk_eq("rst_systick_nz", {31'd0, (rd_v != 32'h0)}, 32'd1);
        chk_reg("rst_rsvd", 7, 32'h0);
        bus.iMemAddr = BASE + 32'h18;
        bus.iMemRead = 1'b0;
        #1;
        chk_eq("no_rd_strobe", bus.oMemReadData, 32'h0);

        // reload timer: TL FFFFFFFE -> FFFFFFFF -> reload FFFFFFFD with IRQ
        bus_wr(BASE + 32'h00, 32'hFFFF_FFFD);
        bus_wr(BASE + 32'h04, 32'hFFFF_FFFE);
        bus_wr(BASE + 32'h08, 32'h0000_0003);
        chk_reg("tl_start", 1, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        chk_reg("tl_max", 1, 32'hFFFF_FFFF);
        chk_eq("irq_pre", {31'd0, oInterrupt}, 32'd0);
        @(posedge clk); #1;
        chk_reg("tl_reload", 1, 32'hFFFF_FFFD);
        chk_eq("irq_set", {31'd0, oInterrupt}, 32'd1);
        chk_reg("tcon_irq", 2, 32'h7);

        // clear IRQ while counting continues
        bus_wr(BASE + 32'h08, 32'h0000_0003);
        chk_eq("irq_clr", {31'd0, oInterrupt}, 32'd0);
        chk_reg("tl_keep_cnt", 1, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        chk_reg("tl_max2", 1, 32'hFFFF_FFFF);

        // CPU write to TL on the overflow cycle wins over reload, IRQ still raised
        bus_wr(BASE + 32'h04, 32'h0000_0005);
        chk_reg("tl_wr_wins", 1, 32'h0000_0005);
        chk_eq("irq_race", {31'd0, oInterrupt}, 32'd1);

        bus_wr(BASE + 32'h08, 32'h0000_0000);
        chk_eq("irq_clr2", {31'd0, oInterrupt}, 32'd0);
        chk_reg("tl_last", 1, 32'h0000_0006);
        @(posedge clk); #1;
        chk_reg("tl_hold", 1, 32'h0000_0006);

        // TCON write on overflow with IRQ enable set must not lose the event
        bus_wr(BASE + 32'h04, 32'hFFFF_FFFF);
        bus_wr(BASE + 32'h08, 32'h0000_0001);
        bus_wr(BASE + 32'h08, 32'h0000_0003);
        chk_reg("tcon_race", 2, 32'h7);
        chk_reg("tl_race_reload", 1, 32'hFFFF_FFFD);
        bus_wr(BASE + 32'h08, 32'h0000_0000);

        // switch synchroniser: 2 cycles of old value, new value from the 3rd
        iSwitch = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        iSwitch = 8'hA5;
        chk_reg("sw_lat0", 4, 32'h0);
        @(posedge clk); #1;
        chk_reg("sw_lat1", 4, 32'h0);
        @(posedge clk); #1;
        chk_reg("sw_lat2", 4, 32'h0000_00A5);
        bus_wr(BASE + 32'h10, 32'h0000_00FF);
        chk_reg("sw_ro", 4, 32'h0000_00A5);

        // out-of-window accesses
        bus_rd(32'h4000_0020, rd_v);
        chk_eq("oow_rd_hi", rd_v, 32'h0);
        bus_rd(32'h0000_0010, rd_v);
        chk_eq("oow_rd_lo", rd_v, 32'h0);
        bus_wr(32'h4000_0020, 32'h0000_0077);
        bus_wr(32'h0000_000C, 32'h0000_0055);
        chk_eq("oow_led", {24'd0, oLed}, 32'h0);
        chk_reg("oow_th", 0, 32'hFFFF_FFFD);

        bus_wr(BASE + 32'h0C, 32'h0000_01FF);
        chk_eq("led_trunc", {24'd0, oLed}, 32'h0000_00FF);
        bus_rd(BASE + 32'h0F, rd_v);
        chk_eq("led_byteoff", rd_v, 32'h0000_00FF);
        bus_wr(BASE + 32'h14, 32'hFFFF_FABC);
        chk_eq("digi_out", {20'd0, oDigi}, 32'h0000_0ABC);
        chk_reg("digi_rd", 5, 32'h0000_0ABC);
        bus_wr(BASE + 32'h1C, 32'h1234_5678);
        chk_reg("rsvd_rd", 7, 32'h0);

        // systick ignores writes and advances by one per edge
        bus_rd(BASE + 32'h18, tick_a);
        bus_wr(BASE + 32'h18, 32'h0000_0000);
        chk_reg("systick_ro", 6, tick_a + 32'd1);

        // asynchronous reset mid-count
        bus_wr(BASE + 32'h04, 32'h0000_0100);
        bus_wr(BASE + 32'h08, 32'h0000_0001);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reg("arst_tl", 1, 32'h0);
        chk_reg("arst_tcon", 2, 32'h0);
        chk_eq("arst_led", {24'd0, oLed}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reg("arst_tl_idle", 1, 32'h0);
        chk_reg("arst_systick", 6, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
